// File: rtl/rrd_exe_skid_stage.sv
// Two-entry skid buffer between register-read decode and execute.
// Buffered micro-ops see branch resolve/mispredict updates and flush every cycle.
module rrd_exe_skid_stage #(
  parameter int XLEN   = 64,
  parameter int BR_W   = 16,
  parameter int ROB_W  = 7,
  parameter int PREG_W = 7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rrd_valid,
  output logic              rrd_ready,
  input  logic [6:0]        rrd_uopc,
  input  logic [BR_W-1:0]   rrd_br_mask,
  input  logic [ROB_W-1:0]  rrd_rob_idx,
  input  logic [PREG_W-1:0] rrd_pdst,
  input  logic [19:0]       rrd_imm_packed,
  input  logic [16:0]       rrd_ctrl,
  input  logic [XLEN-1:0]   rrd_rs1_data,
  input  logic [XLEN-1:0]   rrd_rs2_data,
  input  logic [BR_W-1:0]   brupdate_resolve_mask,
  input  logic [BR_W-1:0]   brupdate_mispredict_mask,
  input  logic              flush,
  output logic              exe_valid,
  input  logic              exe_ready,
  output logic [6:0]        exe_uopc,
  output logic [BR_W-1:0]   exe_br_mask,
  output logic [ROB_W-1:0]  exe_rob_idx,
  output logic [PREG_W-1:0] exe_pdst,
  output logic [19:0]       exe_imm_packed,
  output logic [16:0]       exe_ctrl,
  output logic [XLEN-1:0]   exe_rs1_data,
  output logic [XLEN-1:0]   exe_rs2_data
);

  localparam int PW = 7 + ROB_W + PREG_W + 20 + 17 + 2 * XLEN;

  // Handshake: a transfer happens on a cycle where valid and ready are both high
  // at the rising clock edge; rrd_ready is a function of registered state only.
  logic [1:0]      r_valid;
  logic [BR_W-1:0] r_mask [2];
  logic [PW-1:0]   r_data [2];

  logic [1:0]      w_nxt_valid;
  logic [BR_W-1:0] w_nxt_mask [2];
  logic [PW-1:0]   w_nxt_data [2];

  logic            w_kill0, w_kill1, w_kill_in;
  logic            w_live0, w_live1;
  logic            w_keep0, w_keep1;
  logic            w_deq, w_enq;
  logic [BR_W-1:0] w_in_mask;
  logic [PW-1:0]   w_in_data;

  assign w_kill0   = |(r_mask[0] & brupdate_mispredict_mask);
  assign w_kill1   = |(r_mask[1] & brupdate_mispredict_mask);
  assign w_kill_in = |(rrd_br_mask & brupdate_mispredict_mask);
  assign w_live0   = r_valid[0] & ~w_kill0;
  assign w_live1   = r_valid[1] & ~w_kill1;

  assign rrd_ready = ~(r_valid[0] & r_valid[1]);
  assign exe_valid = w_live0 & ~flush;
  assign w_deq     = exe_valid & exe_ready;
  assign w_enq     = rrd_valid & rrd_ready & ~flush & ~w_kill_in;
  assign w_keep0   = w_live0 & ~w_deq;
  assign w_keep1   = w_live1;

  assign w_in_mask = rrd_br_mask & ~brupdate_resolve_mask;
  assign w_in_data = {rrd_uopc, rrd_rob_idx, rrd_pdst, rrd_imm_packed, rrd_ctrl,
                      rrd_rs1_data, rrd_rs2_data};

  assign exe_br_mask = r_mask[0] & ~brupdate_resolve_mask;
  assign {exe_uopc, exe_rob_idx, exe_pdst, exe_imm_packed, exe_ctrl,
          exe_rs1_data, exe_rs2_data} = r_data[0];

  // Survivors compact toward slot0 in age order; the new op takes the first free slot.
  always_comb begin
    w_nxt_valid   = 2'b00;
    w_nxt_mask[0] = r_mask[0] & ~brupdate_resolve_mask;
    w_nxt_mask[1] = r_mask[1] & ~brupdate_resolve_mask;
    w_nxt_data[0] = r_data[0];
    w_nxt_data[1] = r_data[1];
    if (!flush) begin
      if (w_keep0) begin
        w_nxt_valid[0] = 1'b1;
        if (w_keep1) begin
          w_nxt_valid[1] = 1'b1;
        end else if (w_enq) begin
          w_nxt_valid[1] = 1'b1;
          w_nxt_mask[1]  = w_in_mask;
          w_nxt_data[1]  = w_in_data;
        end
      end else if (w_keep1) begin
        w_nxt_valid[0] = 1'b1;
        w_nxt_mask[0]  = r_mask[1] & ~brupdate_resolve_mask;
        w_nxt_data[0]  = r_data[1];
        if (w_enq) begin
          w_nxt_valid[1] = 1'b1;
          w_nxt_mask[1]  = w_in_mask;
          w_nxt_data[1]  = w_in_data;
        end
      end else if (w_enq) begin
        w_nxt_valid[0] = 1'b1;
        w_nxt_mask[0]  = w_in_mask;
        w_nxt_data[0]  = w_in_data;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid <= 2'b00;
    end else begin
      r_valid <= w_nxt_valid;
    end
  end

  // Payload carries no reset; it is ignored whenever its valid bit is low.
  always_ff @(posedge clock) begin
    r_mask[0] <= w_nxt_mask[0];
    r_mask[1] <= w_nxt_mask[1];
    r_data[0] <= w_nxt_data[0];
    r_data[1] <= w_nxt_data[1];
  end

endmodule

// File: tb/tb_rrd_exe_skid_stage.sv
// Bench for rrd_exe_skid_stage: directed vector table, multi-cycle corner cases,
// then random traffic checked against a queue-based reference model.
module tb_rrd_exe_skid_stage;

  logic        clock;
  logic        reset;
  logic        rrd_valid;
  logic        rrd_ready;
  logic [6:0]  rrd_uopc;
  logic [15:0] rrd_br_mask;
  logic [6:0]  rrd_rob_idx;
  logic [6:0]  rrd_pdst;
  logic [19:0] rrd_imm_packed;
  logic [16:0] rrd_ctrl;
  logic [63:0] rrd_rs1_data;
  logic [63:0] rrd_rs2_data;
  logic [15:0] brupdate_resolve_mask;
  logic [15:0] brupdate_mispredict_mask;
  logic        flush;
  logic        exe_valid;
  logic        exe_ready;
  logic [6:0]  exe_uopc;
  logic [15:0] exe_br_mask;
  logic [6:0]  exe_rob_idx;
  logic [6:0]  exe_pdst;
  logic [19:0] exe_imm_packed;
  logic [16:0] exe_ctrl;
  logic [63:0] exe_rs1_data;
  logic [63:0] exe_rs2_data;

  int n_tests = 0;
  int n_fail  = 0;

  rrd_exe_skid_stage dut (
    .clock(clock), .reset(reset),
    .rrd_valid(rrd_valid), .rrd_ready(rrd_ready), .rrd_uopc(rrd_uopc),
    .rrd_br_mask(rrd_br_mask), .rrd_rob_idx(rrd_rob_idx), .rrd_pdst(rrd_pdst),
    .rrd_imm_packed(rrd_imm_packed), .rrd_ctrl(rrd_ctrl),
    .rrd_rs1_data(rrd_rs1_data), .rrd_rs2_data(rrd_rs2_data),
    .brupdate_resolve_mask(brupdate_resolve_mask),
    .brupdate_mispredict_mask(brupdate_mispredict_mask), .flush(flush),
    .exe_valid(exe_valid), .exe_ready(exe_ready), .exe_uopc(exe_uopc),
    .exe_br_mask(exe_br_mask), .exe_rob_idx(exe_rob_idx), .exe_pdst(exe_pdst),
    .exe_imm_packed(exe_imm_packed), .exe_ctrl(exe_ctrl),
    .exe_rs1_data(exe_rs1_data), .exe_rs2_data(exe_rs2_data)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: an age-ordered queue of buffered ops (at most two)
  typedef struct {
    logic [15:0] mask;
    logic [6:0]  uopc;
    logic [6:0]  rob;
    logic [6:0]  pdst;
    logic [19:0] imm;
    logic [16:0] ctrl;
    logic [63:0] rs1;
    logic [63:0] rs2;
  } ent_t;
  ent_t exp_q[$];

  typedef struct {
    logic        rv;
    logic [6:0]  uopc;
    logic [63:0] rs1;
    logic [15:0] mask;
    logic [15:0] mis;
    logic [15:0] res;
    logic        fl;
    logic        er;
    logic        exp_ready;
    logic        exp_valid;
    logic [6:0]  exp_uopc;
    logic [63:0] exp_rs1;
    logic [15:0] exp_mask;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_exe_valid();
    return (exp_q.size() > 0) && ((exp_q[0].mask & brupdate_mispredict_mask) == 16'h0) && !flush;
  endfunction

  task automatic model_check();
    chk("rrd_ready", rrd_ready, exp_q.size() < 2);
    chk("exe_valid", exe_valid, model_exe_valid());
    if (model_exe_valid()) begin
      chk("exe_uopc", exe_uopc, exp_q[0].uopc);
      chk("exe_br_mask", exe_br_mask, exp_q[0].mask & ~brupdate_resolve_mask);
      chk("exe_rob_idx", exe_rob_idx, exp_q[0].rob);
      chk("exe_pdst", exe_pdst, exp_q[0].pdst);
      chk("exe_imm", exe_imm_packed, exp_q[0].imm);
      chk("exe_ctrl", exe_ctrl, exp_q[0].ctrl);
      chk("exe_rs1", exe_rs1_data, exp_q[0].rs1);
      chk("exe_rs2", exe_rs2_data, exp_q[0].rs2);
    end
  endtask

  task automatic model_update();
    ent_t t[$];
    ent_t e;
    bit   deq, enq;
    deq = model_exe_valid() && exe_ready;
    enq = rrd_valid && (exp_q.size() < 2) && !flush &&
          ((rrd_br_mask & brupdate_mispredict_mask) == 16'h0);
    if (flush) begin
      exp_q.delete();
    end else begin
      for (int i = 0; i < exp_q.size(); i++)
        if ((exp_q[i].mask & brupdate_mispredict_mask) == 16'h0) t.push_back(exp_q[i]);
      if (deq) void'(t.pop_front());
      if (enq) begin
        e.mask = rrd_br_mask; e.uopc = rrd_uopc; e.rob = rrd_rob_idx; e.pdst = rrd_pdst;
        e.imm = rrd_imm_packed; e.ctrl = rrd_ctrl; e.rs1 = rrd_rs1_data; e.rs2 = rrd_rs2_data;
        t.push_back(e);
      end
      for (int i = 0; i < t.size(); i++) t[i].mask = t[i].mask & ~brupdate_resolve_mask;
      exp_q = t;
    end
  endtask

  // One clock: check outputs at the falling edge, advance the model at the rising edge.
  task automatic run_cycle(input bit use_row, input vec_t v);
    @(negedge clock);
    if (use_row) begin
      chk("vec_rrd_ready", rrd_ready, v.exp_ready);
      chk("vec_exe_valid", exe_valid, v.exp_valid);
      if (v.exp_valid) begin
        chk("vec_exe_uopc", exe_uopc, v.exp_uopc);
        chk("vec_exe_rs1", exe_rs1_data, v.exp_rs1);
        chk("vec_exe_br_mask", exe_br_mask, v.exp_mask);
      end
    end else begin
      model_check();
    end
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic add_row(input logic rv, input logic [6:0] uopc, input logic [63:0] rs1,
                         input logic [15:0] mask, input logic [15:0] mis, input logic [15:0] res,
                         input logic fl, input logic er, input logic e_rdy, input logic e_vld,
                         input logic [6:0] e_uopc, input logic [63:0] e_rs1, input logic [15:0] e_mask);
    vec_t v;
    v.rv = rv; v.uopc = uopc; v.rs1 = rs1; v.mask = mask; v.mis = mis; v.res = res;
    v.fl = fl; v.er = er; v.exp_ready = e_rdy; v.exp_valid = e_vld;
    v.exp_uopc = e_uopc; v.exp_rs1 = e_rs1; v.exp_mask = e_mask;
    vt.push_back(v);
  endtask

  task automatic drive_idle();
    rrd_valid = 0; rrd_uopc = 0; rrd_br_mask = 0; rrd_rob_idx = 0; rrd_pdst = 0;
    rrd_imm_packed = 0; rrd_ctrl = 0; rrd_rs1_data = 0; rrd_rs2_data = 0;
    brupdate_resolve_mask = 0; brupdate_mispredict_mask = 0; flush = 0; exe_ready = 0;
  endtask

  task automatic drive_random();
    rrd_valid      = 1'($urandom_range(0, 1));
    rrd_uopc       = 7'($urandom);
    rrd_br_mask    = 16'($urandom_range(0, 15));
    rrd_rob_idx    = 7'($urandom);
    rrd_pdst       = 7'($urandom);
    rrd_imm_packed = 20'($urandom);
    rrd_ctrl       = 17'($urandom);
    rrd_rs1_data   = {32'($urandom), 32'($urandom)};
    rrd_rs2_data   = {32'($urandom), 32'($urandom)};
    brupdate_mispredict_mask = ($urandom_range(0, 7) == 0) ? 16'(1 << $urandom_range(0, 3)) : 16'h0;
    brupdate_resolve_mask    = ($urandom_range(0, 3) == 0) ? 16'(1 << $urandom_range(0, 3)) : 16'h0;
    flush     = ($urandom_range(0, 24) == 0);
    exe_ready = 1'($urandom_range(0, 2) != 0);
  endtask

  initial begin
    vec_t dummy;
    dummy = '{default: '0};
    drive_idle();
    reset = 1'b0;

    //     rv uopc   rs1       mask  mis   res   fl er | rdy vld uopc   rs1       mask
    add_row(1, 7'h19, 64'h5,   16'h0, 16'h0, 16'h0, 0, 1,  1, 0, 7'h00, 64'h0,   16'h0);
    add_row(0, 7'h00, 64'h0,   16'h0, 16'h0, 16'h0, 0, 1,  1, 1, 7'h19, 64'h5,   16'h0);
    add_row(0, 7'h00, 64'h0,   16'h0, 16'h0, 16'h0, 0, 1,  1, 0, 7'h00, 64'h0,   16'h0);
    add_row(1, 7'h0A, 64'hA0,  16'h0, 16'h0, 16'h0, 0, 0,  1, 0, 7'h00, 64'h0,   16'h0);
    add_row(1, 7'h0B, 64'hB0,  16'h0, 16'h0, 16'h0, 0, 0,  1, 1, 7'h0A, 64'hA0,  16'h0);
    add_row(1, 7'h0C, 64'hC0,  16'h0, 16'h0, 16'h0, 0, 0,  0, 1, 7'h0A, 64'hA0,  16'h0);
    add_row(1, 7'h0C, 64'hC0,  16'h0, 16'h0, 16'h0, 0, 0,  0, 1, 7'h0A, 64'hA0,  16'h0);
    add_row(0, 7'h00, 64'h0,   16'h0, 16'h0, 16'h0, 0, 1,  0, 1, 7'h0A, 64'hA0,  16'h0);
    add_row(0, 7'h00, 64'h0,   16'h0, 16'h0, 16'h0, 0, 1,  1, 1, 7'h0B, 64'hB0,  16'h0);
    add_row(0, 7'h00, 64'h0,   16'h0, 16'h0, 16'h0, 0, 1,  1, 0, 7'h00, 64'h0,   16'h0);
    add_row(1, 7'h21, 64'h210, 16'h3, 16'h0, 16'h0, 0, 0,  1, 0, 7'h00, 64'h0,   16'h0);
    add_row(0, 7'h00, 64'h0,   16'h0, 16'h0, 16'h1, 0, 0,  1, 1, 7'h21, 64'h210, 16'h2);
    add_row(0, 7'h00, 64'h0,   16'h0, 16'h0, 16'h0, 0, 0,  1, 1, 7'h21, 64'h210, 16'h2);
    add_row(0, 7'h00, 64'h0,   16'h0, 16'h0, 16'h0, 0, 1,  1, 1, 7'h21, 64'h210, 16'h2);
    add_row(0, 7'h00, 64'h0,   16'h0, 16'h0, 16'h0, 0, 1,  1, 0, 7'h00, 64'h0,   16'h0);
    add_row(1, 7'h31, 64'h310, 16'h4, 16'h0, 16'h0, 0, 0,  1, 0, 7'h00, 64'h0,   16'h0);
    add_row(1, 7'h32, 64'h320, 16'h1, 16'h0, 16'h0, 0, 0,  1, 1, 7'h31, 64'h310, 16'h4);
    add_row(0, 7'h00, 64'h0,   16'h0, 16'h4, 16'h0, 0, 0,  0, 0, 7'h00, 64'h0,   16'h0);
    add_row(0, 7'h00, 64'h0,   16'h0, 16'h0, 16'h0, 0, 0,  1, 1, 7'h32, 64'h320, 16'h1);
    add_row(0, 7'h00, 64'h0,   16'h0, 16'h0, 16'h0, 0, 1,  1, 1, 7'h32, 64'h320, 16'h1);
    add_row(0, 7'h00, 64'h0,   16'h0, 16'h0, 16'h0, 0, 1,  1, 0, 7'h00, 64'h0,   16'h0);
    add_row(1, 7'h41, 64'h410, 16'h0, 16'h0, 16'h0, 0, 0,  1, 0, 7'h00, 64'h0,   16'h0);
    add_row(1, 7'h42, 64'h420, 16'h0, 16'h0, 16'h0, 0, 0,  1, 1, 7'h41, 64'h410, 16'h0);
    add_row(1, 7'h43, 64'h430, 16'h0, 16'h0, 16'h0, 1, 0,  0, 0, 7'h00, 64'h0,   16'h0);
    add_row(0, 7'h00, 64'h0,   16'h0, 16'h0, 16'h0, 0, 1,  1, 0, 7'h00, 64'h0,   16'h0);
    add_row(0, 7'h00, 64'h0,   16'h0, 16'h0, 16'h0, 0, 1,  1, 0, 7'h00, 64'h0,   16'h0);

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("reset_exe_valid", exe_valid, 1'b0);
    chk("reset_rrd_ready", rrd_ready, 1'b1);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Directed vector table
    foreach (vt[i]) begin
      rrd_valid    = vt[i].rv;
      rrd_uopc     = vt[i].uopc;
      rrd_rs1_data = vt[i].rs1;
      rrd_br_mask  = vt[i].mask;
      brupdate_mispredict_mask = vt[i].mis;
      brupdate_resolve_mask    = vt[i].res;
      flush     = vt[i].fl;
      exe_ready = vt[i].er;
      run_cycle(1'b1, vt[i]);
    end

    // Asynchronous reset in the middle of a cycle while full
    drive_idle();
    rrd_valid = 1; rrd_uopc = 7'h51; rrd_rs1_data = 64'h51;
    run_cycle(1'b0, dummy);
    rrd_uopc = 7'h52; rrd_rs1_data = 64'h52;
    run_cycle(1'b0, dummy);
    rrd_valid = 0;
    #1;
    chk("pre_areset_exe_valid", exe_valid, 1'b1);
    chk("pre_areset_rrd_ready", rrd_ready, 1'b0);
    #1;
    reset = 1'b0;
    #1;
    chk("areset_exe_valid", exe_valid, 1'b0);
    chk("areset_rrd_ready", rrd_ready, 1'b1);
    exp_q.delete();
    #2;
    reset = 1'b1;
    exe_ready = 1;
    run_cycle(1'b0, dummy);

    // Random traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      drive_random();
      run_cycle(1'b0, dummy);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rrd_exe_skid_stage.md
Name: rrd_exe_skid_stage

Overview:
- Pipeline register between ALU/mem register-read decode and the execute unit.
- Captures the decoded micro-op plus both operand values read from the register file.
- Two-entry skid buffer, so execute units that are not fully pipelined (e.g. the divider) can backpressure.
- Applies branch-resolution mask updates, mispredict kills and pipeline flush to the buffered micro-ops every cycle.

Parameters:
- XLEN, 64, operand data width
- BR_W, 16, branch-mask width (number of in-flight branch tags)
- ROB_W, 7, ROB index width
- PREG_W, 7, physical register index width

Ports:
- clock  in  1  clock
- reset  in  1  asynchronous, active-low reset
- rrd_valid  in  1  micro-op offered from register-read decode
- rrd_ready  out  1  stage can accept this cycle
- rrd_uopc  in  7  micro-op code
- rrd_br_mask  in  BR_W  branch dependency mask
- rrd_rob_idx  in  ROB_W  ROB index
- rrd_pdst  in  PREG_W  destination physical register
- rrd_imm_packed  in  20  packed immediate
- rrd_ctrl  in  17  {op1_sel[1:0], op2_sel[2:0], imm_sel[2:0], op_fcn[3:0], fcn_dw, br_type[3:0]}
- rrd_rs1_data  in  XLEN  operand 1 value
- rrd_rs2_data  in  XLEN  operand 2 value
- brupdate_resolve_mask  in  BR_W  branch tags resolved this cycle
- brupdate_mispredict_mask  in  BR_W  branch tags mispredicted this cycle
- flush  in  1  pipeline flush (exception/redirect)
- exe_valid  out  1  micro-op presented to execute
- exe_ready  in  1  execute accepts this cycle
- exe_uopc, exe_br_mask, exe_rob_idx, exe_pdst, exe_imm_packed, exe_ctrl, exe_rs1_data, exe_rs2_data  out  widths as inputs  head-entry payload

Behaviour:
- Storage: slot0 (head) and slot1, each holding a valid bit plus the full payload. count = number of valid slots.
- Reset (reset low, asynchronous): both valid bits 0, so exe_valid=0 and rrd_ready=1. Payload registers are not reset. All exe_* data outputs are don't-care while exe_valid=0.
- rrd_ready = (count < 2). It depends only on registered state; there is no combinational path from exe_ready.
- Kill test, evaluated per slot and for the incoming op: kill = |(br_mask & brupdate_mispredict_mask).
- exe_valid = slot0.valid & ~kill(slot0) & ~flush.
- exe_br_mask = slot0.br_mask & ~brupdate_resolve_mask. This is combinational, so resolved bits are already cleared on the output in the same cycle.
- Other exe_* outputs = slot0 payload, combinational from the registers; zero added latency beyond the register.
- Dequeue: occurs when exe_valid & exe_ready.
- Enqueue: occurs when rrd_valid & rrd_ready & ~flush & ~kill(incoming). The stored mask is rrd_br_mask & ~brupdate_resolve_mask.
- Next-state rule, applied in this order within one cycle:
  1. Mark killed slots invalid.
  2. Remove the head if dequeued.
  3. Compact the survivors toward slot0, preserving age order.
  4. Append the enqueued op at the first free slot.
  5. Clear brupdate_resolve_mask bits in every surviving stored br_mask.
- Latency: an op enqueued in cycle N with the buffer empty appears on exe_valid in cycle N+1.
- Enqueue and dequeue in the same cycle are legal at count=1. Count stays 1 and the new op becomes the head.
- Full (count=2): rrd_ready=0 even if exe_ready=1 this cycle; any rrd_valid is ignored.
- Flush: both slots are invalidated at the next edge, regardless of exe_ready, and the incoming op is dropped. Flush takes priority over kill and enqueue.
- Kill of slot0 only while slot1 survives: slot1 moves to slot0 at the next edge.
- Simultaneous resolve and mispredict on different tags: the kill uses the unmodified masks; the resolve clears bits on the survivors.
- Mid-operation reset: reset asserted asynchronously clears the valid bits immediately. Outputs return to the reset values within the same cycle.
- No arithmetic is performed; all payload widths pass through unchanged.

Test Plan:
- Reset release, then rrd_valid=1 with uopc=7'h19, rs1=64'h5, exe_ready=1 -> exe_valid=1 the next cycle with uopc 7'h19 and rs1 5; buffer then drains to count 0.
- exe_ready=0 and three back-to-back ops A, B, C -> A and B accepted; rrd_ready=0 from the cycle after B; C is held off. Raise exe_ready -> A then B dequeue in order and rrd_ready returns to 1.
- Slot0 br_mask=16'h0004, slot1 br_mask=16'h0001, mispredict_mask=16'h0004 -> exe_valid=0 that cycle; the next cycle slot1's op is the head with exe_valid=1 and count=1.
- Stored br_mask=16'h0003, resolve_mask=16'h0001 -> exe_br_mask=16'h0002 in the same cycle; the registered mask is 16'h0002 afterwards.
- count=2 with flush=1 and rrd_valid=1 -> the next cycle exe_valid=0, count=0 and rrd_ready=1; the incoming op is not captured.
- Async reset pulsed mid-cycle with count=2 -> exe_valid falls before the next clock edge; after release, rrd_ready=1.
